// File: rtl/cpl_pkg.sv
// Shared types and constants for the per-FU completion buffer.
//   preg_tag_t  : physical-register tag, $clog2(`PREG_NUMBER) bits
//   CPL_DEPTH   : default number of buffered completions
//   cnt_width() : width of an occupancy counter for a given depth
// `PREG_NUMBER falls back to 64 when the build does not supply it.
`ifndef PREG_NUMBER
`define PREG_NUMBER 64
`endif

package cpl_pkg;

    typedef logic [$clog2(`PREG_NUMBER)-1:0] preg_tag_t;

    localparam int unsigned CPL_DEPTH = 4;

    // Counter must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// Generic show-ahead FIFO: circular storage, wrapping head/tail pointers and a
// separate occupancy counter.
//   clk, reset       : clock, asynchronous active-high reset
//   clear_i          : synchronous empty; wins over push_i/pop_i
//   push_i, wdata_i  : write wdata_i at tail (caller guarantees !full_o)
//   pop_i            : retire the head entry (caller guarantees !empty_o)
//   rdata_o          : entry at head (raw storage, meaningless when empty)
//   count_o, full_o, empty_o : occupancy status from registered state
module tag_fifo
    import cpl_pkg::*;
#(
    parameter int unsigned DEPTH = CPL_DEPTH,
    parameter int unsigned WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [WIDTH-1:0]            wdata_i,
    output logic [WIDTH-1:0]            rdata_o,
    output logic [cnt_width(DEPTH)-1:0] count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push_i) tail_d = tail_q + PW'(1);
            if (pop_i)  head_d = head_q + PW'(1);
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; contents are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[tail_q] <= wdata_i;
    end

    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fu_complete_buffer.sv
// Per-FU completion staging queue in front of the CDB arbiter. Holds completed
// destination tags and presents the oldest to the CDB until it is granted.
//   clk, reset  : clock, asynchronous active-high reset
//   flush_i     : squash all buffered entries (priority over push/pop)
//   valid_i     : FU completes a result this cycle, tag in tag_i
//   ready_o     : a push is accepted this cycle (!full, registered state only)
//   complete_o  : request to CDB; tag_o is the tag presented (0 when idle)
//   grant_i     : CDB accepted this FU's tag; retires the head entry
//   count_o     : number of buffered entries
//   overflow_o  : sticky, set when valid_i arrives while full; cleared by reset
// Optional: define CPL_BYPASS_EN for a zero-latency path from valid_i/tag_i to
// complete_o/tag_o while the buffer is empty.
module fu_complete_buffer
    import cpl_pkg::*;
#(
    parameter int unsigned DEPTH = CPL_DEPTH,
    parameter int unsigned TAG_W = $clog2(`PREG_NUMBER)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_i,
    input  logic                        valid_i,
    input  logic [TAG_W-1:0]            tag_i,
    output logic                        ready_o,
    output logic                        complete_o,
    output logic [TAG_W-1:0]            tag_o,
    input  logic                        grant_i,
    output logic [cnt_width(DEPTH)-1:0] count_o,
    output logic                        overflow_o
);

    logic             fifo_push;
    logic             fifo_pop;
    logic [TAG_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             overflow_q, overflow_d;

    tag_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (tag_i),
        .rdata_o (fifo_rdata),
        .count_o (count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A same-cycle pop never frees a slot for a push while full.
    assign ready_o = !fifo_full;

`ifdef CPL_BYPASS_EN
    logic bypass;

    assign bypass = fifo_empty && valid_i && !flush_i;

    always_comb begin
        complete_o = !fifo_empty || bypass;
        if (!fifo_empty) begin
            tag_o = fifo_rdata;
        end else if (bypass) begin
            tag_o = tag_i;
        end else begin
            tag_o = '0;
        end
    end

    // A granted bypass tag has already left; it must not also be stored.
    assign fifo_pop  = !fifo_empty && grant_i && !flush_i;
    assign fifo_push = valid_i && ready_o && !flush_i && !(bypass && grant_i);
`else
    always_comb begin
        complete_o = !fifo_empty;
        tag_o      = fifo_empty ? '0 : fifo_rdata;
    end

    assign fifo_pop  = complete_o && grant_i && !flush_i;
    assign fifo_push = valid_i && ready_o && !flush_i;
`endif

    assign overflow_d = overflow_q || (valid_i && !ready_o);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fu_complete_buffer.sv
module tb_fu_complete_buffer;
    import cpl_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = $clog2(`PREG_NUMBER);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef CPL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          flush_i, valid_i, grant_i;
    logic [TW-1:0] tag_i;
    logic          ready_o, complete_o, overflow_o;
    logic [TW-1:0] tag_o;
    logic [CW-1:0] count_o;

    fu_complete_buffer #(
        .DEPTH (DEPTH),
        .TAG_W (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .tag_i      (tag_i),
        .ready_o    (ready_o),
        .complete_o (complete_o),
        .tag_o      (tag_o),
        .grant_i    (grant_i),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of tags in completion order and a sticky flag.
    int mq[$];
    bit movf;

    typedef struct {
        bit fl; bit v; int t; bit g;
        bit e_cpl; int e_tag; int e_cnt; bit e_rdy; bit e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input bit cpl, input int tg, input int cnt,
                           input bit rdy, input bit ovf);
        chk({nm, ".complete"}, int'(complete_o), int'(cpl));
        chk({nm, ".tag"},      int'(tag_o),      tg);
        chk({nm, ".count"},    int'(count_o),    cnt);
        chk({nm, ".ready"},    int'(ready_o),    int'(rdy));
        chk({nm, ".overflow"}, int'(overflow_o), int'(ovf));
    endtask

    function automatic bit m_bypass();
        return BYP && mq.size() == 0 && valid_i && !flush_i;
    endfunction

    task automatic check_model(input string nm);
        bit cpl;
        int tg;
        cpl = (mq.size() > 0) || m_bypass();
        tg  = (mq.size() > 0) ? mq[0] : (m_bypass() ? int'(tag_i) : 0);
        chk_all(nm, cpl, tg, mq.size(), mq.size() < DEPTH, movf);
    endtask

    // Apply the rules at a clock edge using the inputs held across it.
    task automatic model_update();
        bit has_room, granted;
        has_room = mq.size() < DEPTH;
        granted  = grant_i && ((mq.size() > 0) || m_bypass());
        if (valid_i && !has_room) movf = 1'b1;
        if (flush_i) begin
            mq.delete();
        end else if (m_bypass() && grant_i) begin
            // tag left through the bypass; nothing stored
        end else begin
            if (granted && mq.size() > 0) void'(mq.pop_front());
            if (valid_i && has_room) mq.push_back(int'(tag_i));
        end
    endtask

    task automatic drive(input bit fl, input bit v, input int t, input bit g);
        @(negedge clk);
        flush_i = fl; valid_i = v; tag_i = TW'(t); grant_i = g;
        #1;
    endtask

    task automatic commit();
        @(posedge clk);
        model_update();
    endtask

    function automatic vec_t mk(input bit fl, input bit v, input int t, input bit g,
                                input bit c, input int et, input int n, input bit r,
                                input bit o);
        vec_t x;
        x.fl = fl; x.v = v; x.t = t; x.g = g;
        x.e_cpl = c; x.e_tag = et; x.e_cnt = n; x.e_rdy = r; x.e_ovf = o;
        return x;
    endfunction

    initial begin
        reset = 1'b1; flush_i = 0; valid_i = 0; grant_i = 0; tag_i = '0;
        mq.delete(); movf = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Outputs expected during each cycle, before the edge that applies the inputs.
        // push 8,12,9 then drain with grants
        tbl.push_back(mk(0, 1, 8,  0, BYP, BYP ? 8 : 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 12, 0, 1, 8,  1, 1, 0));
        tbl.push_back(mk(0, 1, 9,  0, 1, 8,  2, 1, 0));
        tbl.push_back(mk(0, 0, 0,  1, 1, 8,  3, 1, 0));
        tbl.push_back(mk(0, 0, 0,  1, 1, 12, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0,  1, 1, 9,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0,  0, 1, 0));
        // fill with 1..4, push 5 while full and granting
        tbl.push_back(mk(0, 1, 1,  0, BYP, BYP ? 1 : 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 2,  0, 1, 1,  1, 1, 0));
        tbl.push_back(mk(0, 1, 3,  0, 1, 1,  2, 1, 0));
        tbl.push_back(mk(0, 1, 4,  0, 1, 1,  3, 1, 0));
        tbl.push_back(mk(0, 1, 5,  1, 1, 1,  4, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1, 1, 2,  3, 1, 1));
        tbl.push_back(mk(0, 0, 0,  1, 1, 3,  2, 1, 1));
        tbl.push_back(mk(0, 0, 0,  1, 1, 4,  1, 1, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0,  0, 1, 1));
        // steady state at count 2, pointers wrap
        tbl.push_back(mk(0, 1, 18, 0, BYP, BYP ? 18 : 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 19, 0, 1, 18, 1, 1, 1));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0, 1, 20 + i, 1, 1, 18 + i, 2, 1, 1));
        tbl.push_back(mk(0, 0, 0,  1, 1, 24, 2, 1, 1));
        tbl.push_back(mk(0, 0, 0,  1, 1, 25, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0,  0, 1, 1));
        // flush with count 3 plus same-cycle valid(7) and grant
        tbl.push_back(mk(0, 1, 30, 0, BYP, BYP ? 30 : 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 31, 0, 1, 30, 1, 1, 1));
        tbl.push_back(mk(0, 1, 32, 0, 1, 30, 2, 1, 1));
        tbl.push_back(mk(1, 1, 7,  1, 1, 30, 3, 1, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0,  0, 1, 1));
        tbl.push_back(mk(0, 0, 0,  1, 0, 0,  0, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].fl, tbl[i].v, tbl[i].t, tbl[i].g);
            chk_all($sformatf("tbl[%0d]", i), tbl[i].e_cpl, tbl[i].e_tag, tbl[i].e_cnt,
                    tbl[i].e_rdy, tbl[i].e_ovf);
            commit();
        end

        // Asynchronous reset with three entries buffered and overflow set.
        drive(0, 1, 40, 0); commit();
        drive(0, 1, 41, 0); commit();
        drive(0, 1, 42, 0); commit();
        drive(0, 0, 0, 0);
        chk("pre_reset.count", int'(count_o), 3);
        reset = 1'b1;
        #1;
        chk_all("async_reset", 0, 0, 0, 1, 0);
        mq.delete(); movf = 0;
        @(negedge clk);
        reset = 1'b0;

        // Empty buffer, valid 16 with grant.
        drive(0, 1, 16, 1);
        chk_all("bypass_cycle", BYP, BYP ? 16 : 0, 0, 1, 0);
        commit();
        drive(0, 0, 0, 0);
        chk_all("bypass_next", !BYP, BYP ? 0 : 16, BYP ? 0 : 1, 1, 0);
        commit();
        drive(0, 0, 0, 1); commit();
        drive(0, 0, 0, 0);
        chk_all("bypass_drained", 0, 0, 0, 1, 0);
        commit();

        // Random traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 60,
                  int'($urandom_range(0, (1 << TW) - 1)), $urandom_range(0, 99) < 45);
            check_model("rand");
            commit();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_complete_buffer.md
Name: fu_complete_buffer

Overview:
Per-FU completion staging queue that sits directly upstream of the CDB arbiter. One instance is placed per functional unit. It absorbs completed destination tags from its FU and presents the oldest one to the CDB as a complete request. It retires that entry only when the CDB grants the FU (FU_complete_en from the CDB), so an FU can keep completing while it loses CDB arbitration.

Parameters:
DEPTH, 4, number of buffered completions (power of two, >= 2)
TAG_W, $clog2(`PREG_NUMBER), width of a physical-register tag

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush_i  input  1  synchronous squash of all buffered entries (branch mispredict recovery)
valid_i  input  1  FU has a completed result this cycle
tag_i  input  TAG_W  destination preg tag of the completing result
ready_o  output  1  buffer can accept a push this cycle
complete_o  output  1  request to CDB; drives one bit of the CDB FU_complete_i
tag_o  output  TAG_W  tag presented to CDB; drives one entry of the CDB completed_tag_i
grant_i  input  1  CDB accepted this FU's tag this cycle (the CDB FU_complete_en_o bit)
count_o  output  $clog2(DEPTH)+1  number of valid entries
overflow_o  output  1  sticky error: push attempted while full

Behaviour:
- Storage: circular FIFO with DEPTH entries, head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a separate count register (full = count==DEPTH, empty = count==0).
- Reset (asynchronous, active-high): head=0, tail=0, count=0, overflow_o=0. Outputs immediately become complete_o=0, tag_o=0, ready_o=1, count_o=0. Entry contents are don't-care.
- Presentation (combinational):
  - complete_o = !empty.
  - tag_o = entry[head] when !empty; otherwise 0. This matches the CDB expectation of zero tags when idle.
- Handshake:
  - pop when complete_o && grant_i.
  - push when valid_i && ready_o.
  - grant_i while complete_o=0 is ignored and has no effect.
- ready_o = !full (registered state only). When full, a same-cycle pop does NOT open a push slot; ready_o stays 0.
- valid_i while !ready_o: the tag is dropped, state is unchanged, and overflow_o is set at the next edge. overflow_o stays set until reset.
- Simultaneous push and pop (non-full, non-empty): count unchanged, head and tail both advance, ordering is preserved.
- Latency: a push at edge N is presented from cycle N+1. This is a minimum of 1 cycle without the optional feature.
- flush_i (synchronous):
  - Has priority over push and pop: at the edge, head=tail=0 and count=0.
  - A same-cycle valid_i is discarded.
  - A same-cycle grant_i does not pop; the tag was broadcast but is squashed anyway.
  - overflow_o is unaffected.
- Ordering: strict FIFO; tags leave in completion order.

Optional Feature:
Macro CPL_BYPASS_EN.
- Defined:
  - When the buffer is empty and valid_i=1 (and flush_i=0), complete_o=1 and tag_o=tag_i in the same cycle.
  - If grant_i=1 that cycle, nothing is written and count stays 0 (zero-latency path).
  - If grant_i=0, the tag is pushed normally.
- Undefined: no combinational path from valid_i/tag_i to complete_o/tag_o; minimum latency is 1 cycle.

Decomposition:
- Package cpl_pkg:
  - preg_tag_t typedef (logic [$clog2(`PREG_NUMBER)-1:0]).
  - CPL_DEPTH default constant.
  - Count width function.
- One natural sub-module, tag_fifo: a generic show-ahead FIFO holding storage, pointers and count.
  - fu_complete_buffer adds the CDB handshake, flush priority, overflow flag and bypass mux.

Test Plan:
- Reset: assert reset mid-run with 3 entries buffered -> complete_o=0, tag_o=0, count_o=0, ready_o=1 immediately, before any clock edge.
- Push tags 8, 12, 9 with grant_i=0 -> count_o=3 and tag_o=8; grant for 3 cycles -> tag_o sequence 8, 12, 9; then complete_o=0, tag_o=0.
- Fill to 4 (tags 1-4), then valid_i with tag 5 while granting -> pop of 1 occurs, 5 is dropped, overflow_o=1; drain order is 2, 3, 4.
- Steady state at count=2 with valid_i=1 and grant_i=1 for 6 cycles (tags 20-25) -> count_o stays 2 and the output order is preserved across pointer wrap.
- flush_i with count=3 plus same-cycle valid_i (tag 7) and grant_i -> count_o=0, complete_o=0 next cycle, tag 7 never appears.
- With CPL_BYPASS_EN, empty buffer, valid_i with tag 16 and grant_i=1 -> complete_o=1 and tag_o=16 in the same cycle, count_o remains 0. Without CPL_BYPASS_EN, the same stimulus gives complete_o=0 that cycle and tag_o=16 on the next cycle.
